// File: rtl/toggle_decoder.sv
// -----------------------------------------------------------------------------
// toggle_decoder
//
// Receive-side companion to a T flip-flop stage. The toggled level Q_in is
// brought into the Clk domain through a three-flop chain; every level change
// seen between the last two flops is re-emitted as a one-cycle T_out pulse.
// A running toggle count is kept, and a small watchdog FSM raises Stuck when
// no toggle has been consumed for TIMEOUT edges.
//
// Build option:
//   TOGGLE_DECODER_SAT_EN  defined   -> Count saturates at 2^WIDTH-1
//                          undefined -> Count wraps modulo 2^WIDTH
//
// Reset is asynchronous, active-low (Reset). Clr is a synchronous clear of
// the counter and the watchdog only; the synchronizer is never cleared so a
// level change already in flight is still decoded after Clr.
// -----------------------------------------------------------------------------
module toggle_decoder #(
  parameter int WIDTH   = 8,   // toggle counter width (>= 2)
  parameter int TIMEOUT = 16   // idle edges before Stuck asserts (>= 2)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Q_in,
  input  logic             Clr,
  output logic             T_out,
  output logic             Level,
  output logic [WIDTH-1:0] Count,
  output logic             Stuck
);

  // Idle counter only has to reach TIMEOUT-1, so ceil(log2(TIMEOUT)) bits.
  localparam int ICW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [ICW-1:0]   IDLE_LIMIT = ICW'(TIMEOUT - 1);
  localparam logic [ICW-1:0]   IDLE_ZERO  = {ICW{1'b0}};
  localparam logic [ICW-1:0]   IDLE_ONE   = {{(ICW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};

  // Watchdog state encoding; 2'b11 is unreachable and recovers to IDLE.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACTIVE = 2'b01;
  localparam logic [1:0] ST_STUCK  = 2'b10;

  // Synchronizer chain
  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Decoded toggle event (one cycle wide, purely from flops)
  logic w_toggle;

  // Watchdog
  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic [ICW-1:0] r_idle;
  logic [ICW-1:0] w_idle_nxt;
  logic           w_stuck;

  // Toggle counter
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;

  // ---------------------------------------------------------------------------
  // Synchronizer: Q_in is asynchronous; s1 may go metastable, s2 is the
  // settled level and s3 is its one-cycle-old copy used for edge detection.
  // ---------------------------------------------------------------------------

  // Three-flop synchronizer; reset to 0 to match a T flip-flop reset state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= Q_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Any difference between the settled level and its delayed copy is a toggle.
  assign w_toggle = r_s2 ^ r_s3;

  // ---------------------------------------------------------------------------
  // Toggle counter
  // ---------------------------------------------------------------------------

  // Next count: Clr wins over a coincident toggle, which is then dropped.
  always_comb begin
    w_count_nxt = r_count;
    if (Clr) begin
      w_count_nxt = CNT_ZERO;
    end else if (w_toggle) begin
`ifdef TOGGLE_DECODER_SAT_EN
      if (r_count == CNT_MAX) begin
        w_count_nxt = r_count;
      end else begin
        w_count_nxt = r_count + CNT_ONE;
      end
`else
      w_count_nxt = r_count + CNT_ONE;
`endif
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Counter register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_count <= CNT_ZERO;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog FSM
  //   IDLE   : nothing seen since reset/Clr; waits for the first toggle.
  //   ACTIVE : counts idle edges since the last toggle.
  //   STUCK  : idle for TIMEOUT edges; any toggle re-arms to ACTIVE.
  // ---------------------------------------------------------------------------

  // State and idle-counter registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_idle  <= IDLE_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_idle  <= w_idle_nxt;
    end
  end

  // Next-state and idle-counter update; Clr forces IDLE regardless of state.
  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle;
    if (Clr) begin
      w_state_nxt = ST_IDLE;
      w_idle_nxt  = IDLE_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_toggle) begin
            w_state_nxt = ST_ACTIVE;
            w_idle_nxt  = IDLE_ZERO;
          end else begin
            w_state_nxt = ST_IDLE;
            w_idle_nxt  = IDLE_ZERO;
          end
        end
        ST_ACTIVE: begin
          if (w_toggle) begin
            w_state_nxt = ST_ACTIVE;
            w_idle_nxt  = IDLE_ZERO;
          end else if (r_idle == IDLE_LIMIT) begin
            // TIMEOUT edges have now passed since the consuming edge.
            w_state_nxt = ST_STUCK;
            w_idle_nxt  = IDLE_ZERO;
          end else begin
            w_state_nxt = ST_ACTIVE;
            w_idle_nxt  = r_idle + IDLE_ONE;
          end
        end
        ST_STUCK: begin
          if (w_toggle) begin
            w_state_nxt = ST_ACTIVE;
            w_idle_nxt  = IDLE_ZERO;
          end else begin
            w_state_nxt = ST_STUCK;
            w_idle_nxt  = IDLE_ZERO;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idle_nxt  = IDLE_ZERO;
        end
      endcase
    end
  end

  // Output decode: Stuck is a pure function of the registered state.
  always_comb begin
    w_stuck = 1'b0;
    case (r_state)
      ST_IDLE:   w_stuck = 1'b0;
      ST_ACTIVE: w_stuck = 1'b0;
      ST_STUCK:  w_stuck = 1'b1;
      default:   w_stuck = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign T_out = w_toggle;
  assign Level = r_s2;
  assign Count = r_count;
  assign Stuck = w_stuck;

endmodule

// File: doc/toggle_decoder.md
# toggle_decoder

Receive-side companion to the T flip-flop: takes the level output of a toggle stage (possibly from another clock domain), synchronizes it, and recovers the original toggle events as one-cycle `T_out` pulses. It also keeps a running toggle count and flags a stalled source through a small watchdog state machine. It sits downstream of any T flip-flop or toggle-based ripple stage in the lab designs. Bench use: checking toggle sequences against the T stimulus.

## Interface
Parameters:
- `WIDTH`, 8: toggle counter width in bits (≥2).
- `TIMEOUT`, 16: cycles without a toggle before `Stuck` asserts (≥2).

Ports:
- `Clk`  input  1  system clock; all state changes on the rising edge.
- `Reset`  input  1  reset, asynchronous and active-low; `Reset`=0 forces the reset state immediately.
- `Q_in`  input  1  toggled level from the source stage; asynchronous to `Clk`.
- `Clr`  input  1  synchronous clear of count and watchdog, active-high.
- `T_out`  output  1  one-cycle pulse per detected level change of `Q_in`.
- `Level`  output  1  synchronized copy of `Q_in`.
- `Count`  output  WIDTH  number of toggles since reset or `Clr`.
- `Stuck`  output  1  high while the watchdog is in STUCK.

## Operation
- Sync chain of three flops: `s1`<=`Q_in`, `s2`<=`s1`, `s3`<=`s2`. `Level` = `s2`. `T_out` = `s2` XOR `s3` (combinational from flops, so glitch-free and exactly one cycle wide per change).
- Reset loads `s1`=`s2`=`s3`=0. A `Q_in` held high across reset release therefore decodes as one toggle, consistent with a T flip-flop resetting to Q=0.
- Counter: on each edge with `T_out`=1 and `Clr`=0, `Count` increments. Default behaviour wraps from 2^WIDTH−1 to 0.
- Watchdog FSM, with 2-bit state and an idle counter sized ceil(log2(TIMEOUT)):
  - IDLE (reset state): goes to ACTIVE on `T_out`=1, with idle counter set to 0.
  - ACTIVE: on `T_out`=1, idle counter is set to 0. Otherwise, if the idle counter equals TIMEOUT−1, go to STUCK; otherwise increment it.
  - STUCK: `Stuck`=1. On `T_out`=1, go to ACTIVE with idle counter set to 0. The toggle is also counted.
- `Clr`=1 at an edge sets `Count` to 0, the state to IDLE and the idle counter to 0. `Clr` has priority over a simultaneous `T_out`, and that toggle is not counted. The sync chain is unaffected by `Clr`.
- Reset asserted mid-operation returns everything to reset values immediately, and any toggle in flight in the chain is lost.

## Timing
- Reset values: `T_out`=0, `Level`=0, `Count`=0, `Stuck`=0, state IDLE.
- Latency: a change of `Q_in` set up before edge k appears as `Level` changing after edge k+1.
  - `T_out` is high from edge k+1 to edge k+2.
  - `Count` increments at edge k+2.
- Minimum resolvable toggle spacing is 2 cycles. Closer changes are lost or merged by the synchronizer, which is an accepted limitation.
- `Stuck` rises TIMEOUT edges after the edge that consumed the last `T_out`, for example edge e+TIMEOUT when the toggle was counted at edge e.
- `Stuck` falls at the edge that consumes the next `T_out`.
- Toggles arriving on consecutive cycles each reset the idle counter, so there is no spurious timeout.

## Configuration
- `TOGGLE_DECODER_SAT_EN`:
  - When defined, `Count` saturates at 2^WIDTH−1 and further toggles leave it there. `T_out` and the watchdog are unaffected.
  - When undefined, `Count` wraps modulo 2^WIDTH.

## Test plan
- Reset check: assert `Reset`=0 for 1 ns at t=0, with `Clk` period 10 ns and `Q_in`=0 → all outputs 0 and `Stuck`=0 for 100 ns with no toggles (state stays IDLE).
- Single toggle: `Q_in` 0→1 just before edge k → `T_out` high for exactly one cycle starting at edge k+1, `Level`=1 from edge k+1, `Count`=1 after edge k+2.
- Burst: 5 toggles of `Q_in` spaced 20 ns apart (the T flip-flop stimulus pattern) → exactly 5 `T_out` pulses, `Count`=5, final `Level`=1.
- Watchdog with TIMEOUT=16:
  - One toggle, then `Q_in` held → `Stuck`=1 exactly 16 edges after the counting edge.
  - A further toggle → `Stuck`=0 at its counting edge and `Count` increments.
- Clear priority: `Clr`=1 on the same edge as a `T_out` pulse with `Count`=3 → `Count`=0 and state IDLE, and the next toggle gives `Count`=1.
- Width boundary with WIDTH=3, 9 toggles → `Count`=1 without the macro, `Count`=7 with `TOGGLE_DECODER_SAT_EN`.
